// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detection with a multi-cycle stall and branch flush for the 5-stage core.
// Outputs are combinational from state and inputs. Optional counters: define HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int unsigned LOAD_STALL = 1,
    parameter logic [6:0]  OP_LOAD    = 7'b0000011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] ex_opcode,
    input  logic [4:0] ex_rd,
    input  logic       ex_we,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_branch_taken,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic {IDLE, STALL} state_t;

    localparam bit         MULTI_CYCLE = (LOAD_STALL > 1);
    localparam logic [2:0] CNT_INIT    = 3'(LOAD_STALL - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       hazard;

    assign hazard = (ex_opcode == OP_LOAD) && ex_we && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The bubble pushes the load out of EX, so the remaining stall cycles are counted, not re-detected.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (ex_branch_taken) begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard && MULTI_CYCLE) begin
                        state_nxt = STALL;
                        cnt_nxt   = CNT_INIT;
                    end
                end
                STALL: begin
                    if (cnt <= 3'd1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            busy = (state == STALL);
            if (ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if ((state == STALL) || hazard) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            stall_cnt <= stall_cnt + 32'(pc_stall);
            flush_cnt <= flush_cnt + 32'(ifid_flush);
        end
    end
`endif

endmodule
